sprite_fetch: RTL and testbench
===============================

Name: sprite_fetch

Overview:
- Memory-side reader for the sprite/background address generators (score digits, game-over banner, final-grade screen).
- Accepts 25-bit pixel addresses through a valid/ready handshake and issues word reads on the 16-bit external image memory port (pipelined-read, waitrequest style).
- Returns the addressed 8-bit palette index to the colour mapper, in request order.
- Tracks outstanding reads with a tag FIFO, so several pixels can be in flight while memory latency is hidden.

Parameters:
- ADDR_W, 25, pixel (byte) address width from the address generators
- DATA_W, 16, external memory word width
- MAX_OUT, 4, maximum outstanding reads (tag FIFO depth; power of two)

Ports:
- Clk  input  1  system clock
- Reset  input  1  asynchronous active-high reset
- req_valid  input  1  address request valid
- req_ready  output  1  request accepted when req_valid && req_ready
- req_addr  input  ADDR_W  pixel byte address
- mem_read  output  1  memory read command
- mem_address  output  ADDR_W-1  word address = req_addr >> 1
- mem_waitrequest  input  1  memory stalls the current command
- mem_readdata  input  DATA_W  returned word
- mem_readdatavalid  input  1  mem_readdata valid (in-order responses)
- pix_valid  output  1  one-cycle strobe, pix_index valid
- pix_index  output  8  selected byte
- outstanding  output  3  current in-flight count (0..MAX_OUT)
- err  output  1  sticky protocol error flag

Behaviour:
- Reset (async): mem_read=0, mem_address=0, pix_valid=0, pix_index=0, outstanding=0, err=0, tag FIFO empty. req_ready=1 after reset.
- Command FSM has two states, IDLE and ISSUE.
  - IDLE: mem_read=0.
  - On accept: mem_address <= req_addr[ADDR_W-1:1]; push req_addr[0] into tag FIFO; outstanding+1; go to ISSUE.
  - ISSUE: mem_read=1 with address held stable while mem_waitrequest=1.
  - When mem_waitrequest=0, the command is issued that cycle. The FSM returns to IDLE, or stays in ISSUE with the new address if a request is accepted in the same cycle.
- req_ready is combinational: (state==IDLE || !mem_waitrequest) && (outstanding < MAX_OUT).
  - A response in the same cycle does not free a credit until the next cycle.
  - Back-to-back issue gives 1 request/cycle when memory does not stall.
- Response path: on mem_readdatavalid with outstanding>0:
  - Pop the tag FIFO and decrement outstanding.
  - Next cycle: pix_valid=1 and pix_index = tag ? mem_readdata[15:8] : mem_readdata[7:0] (even address = low byte).
  - Latency is exactly 1 cycle from readdatavalid to pix_valid.
  - pix_index holds its value until the next response.
- Simultaneous accept and response: push and pop in the same cycle; outstanding unchanged.
- Stray mem_readdatavalid with outstanding==0: data dropped, no pix_valid, err <= 1. err is sticky until Reset.
- Widths:
  - outstanding is 3 bits and never exceeds MAX_OUT; increment and decrement saturate nowhere, because credit checking makes overflow impossible.
  - Tag FIFO pointers are log2(MAX_OUT)+1 bits, wrapping mod 2*MAX_OUT.
- The memory controller shares Reset. Reset mid-operation discards all in-flight tags. Responses arriving afterwards are treated as stray and set err.

Decomposition:
- sprite_pkg holds:
  - ADDR_W and DATA_W
  - image base offsets: DIGIT_BASE=1166272, DIGIT_STRIDE=57600, GAMEOVER_BASE=77760, GRADE_BASE=1511872
  - screen geometry constants
  - typedef fetch_state_t {IDLE, ISSUE}
- One sub-module: tag_fifo. It is a parameterised 1-bit-wide, MAX_OUT-deep synchronous FIFO with full and empty outputs, async reset, and push/pop allowed in the same cycle.

Test Plan:
- Reset: assert Reset mid-cycle -> all outputs 0 immediately, req_ready=1 after release.
- Single odd read: req_addr=25'd1166273, readdata 16'hAB12 two cycles after issue -> mem_address=583136, pix_valid one cycle after readdatavalid, pix_index=8'hAB. Repeating with req_addr=25'd1166272 -> 8'h12.
- Stall: mem_waitrequest=1 for 3 cycles -> mem_read=1, mem_address stable, req_ready=0 throughout. Issue occurs on the 4th cycle.
- Credits: 4 back-to-back requests, no responses -> outstanding=4, req_ready=0. One readdatavalid -> outstanding=3, req_ready=1 on the following cycle.
- Ordering: requests with addresses 0,1,2,3 and responses 16'h2211, 16'h2211, 16'h4433, 16'h4433 -> pix_index sequence 11,22,33,44.
- Stray and reset: readdatavalid with outstanding=0 -> err=1, no pix_valid. Reset with 2 reads in flight -> outstanding=0, err=0; a late response then sets err=1.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared constants and types for the sprite/background memory reader.
// Image base offsets and screen geometry are used by the address generators.
package sprite_pkg;

    localparam int unsigned ADDR_W = 25;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned PIX_W  = 8;

    localparam int unsigned DIGIT_BASE    = 1166272;
    localparam int unsigned DIGIT_STRIDE  = 57600;
    localparam int unsigned GAMEOVER_BASE = 77760;
    localparam int unsigned GRADE_BASE    = 1511872;

    localparam int unsigned SCREEN_W = 640;
    localparam int unsigned SCREEN_H = 480;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } fetch_state_t;

    // Even byte address lives in the low half of the memory word.
    function automatic logic [PIX_W-1:0] select_byte(input logic [DATA_W-1:0] word,
                                                     input logic odd);
        return odd ? word[15:8] : word[7:0];
    endfunction

endpackage

// File: rtl/tag_fifo.sv
// 1-bit-wide tag FIFO remembering which byte half each in-flight read wants.
// Pointers carry one extra wrap bit to distinguish full from empty.
module tag_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic push_i,
    input  logic data_i,
    input  logic pop_i,
    output logic data_o,
    output logic full_o,
    output logic empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W:0]   wr_q, wr_d;
    logic [PTR_W:0]   rd_q, rd_d;
    logic [DEPTH-1:0] mem_q, mem_d;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[PTR_W] != rd_q[PTR_W]) && (wr_q[PTR_W-1:0] == rd_q[PTR_W-1:0]);
    assign data_o  = mem_q[rd_q[PTR_W-1:0]];

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        mem_d = mem_q;
        if (push_i && !full_o) begin
            mem_d[wr_q[PTR_W-1:0]] = data_i;
            wr_d = wr_q + (PTR_W+1)'(1);
        end
        if (pop_i && !empty_o) begin
            rd_d = rd_q + (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            mem_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/sprite_fetch.sv
// Pixel-address to palette-index reader: issues pipelined word reads and returns
// the addressed byte in request order, with up to MAX_OUT reads in flight.
module sprite_fetch
    import sprite_pkg::*;
#(
    parameter int unsigned MAX_OUT = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              mem_read,
    output logic [ADDR_W-2:0] mem_address,
    input  logic              mem_waitrequest,
    input  logic [DATA_W-1:0] mem_readdata,
    input  logic              mem_readdatavalid,
    output logic              pix_valid,
    output logic [PIX_W-1:0]  pix_index,
    output logic [2:0]        outstanding,
    output logic              err
);

    localparam int unsigned CNT_W = 3;

    fetch_state_t      state_q, state_d;
    logic              mem_read_q;
    logic [ADDR_W-2:0] mem_addr_q, mem_addr_d;
    logic              pix_valid_q;
    logic [PIX_W-1:0]  pix_index_q, pix_index_d;
    logic [CNT_W-1:0]  out_q, out_d;
    logic              err_q, err_d;

    logic accept, resp;
    logic tag_head, fifo_full, fifo_empty;

    // A credit is free whenever the tag FIFO has room; same-cycle pops don't count.
    assign req_ready = ((state_q == IDLE) || !mem_waitrequest) && !fifo_full;
    assign accept    = req_valid && req_ready;
    assign resp      = mem_readdatavalid && !fifo_empty;

    tag_fifo #(
        .DEPTH (MAX_OUT)
    ) u_tag_fifo (
        .clk_i   (Clk),
        .rst_i   (Reset),
        .push_i  (accept),
        .data_i  (req_addr[0]),
        .pop_i   (resp),
        .data_o  (tag_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        pix_index_d = pix_index_q;
        err_d       = err_q;
        out_d       = out_q + CNT_W'(accept) - CNT_W'(resp);

        case (state_q)
            IDLE: begin
                if (accept) state_d = ISSUE;
            end
            ISSUE: begin
                if (!mem_waitrequest) state_d = accept ? ISSUE : IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (accept) mem_addr_d = req_addr[ADDR_W-1:1];
        if (resp)   pix_index_d = select_byte(mem_readdata, tag_head);
        if (mem_readdatavalid && fifo_empty) err_d = 1'b1;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            mem_read_q  <= 1'b0;
            mem_addr_q  <= '0;
            pix_valid_q <= 1'b0;
            pix_index_q <= '0;
            out_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_read_q  <= (state_d == ISSUE);
            mem_addr_q  <= mem_addr_d;
            pix_valid_q <= resp;
            pix_index_q <= pix_index_d;
            out_q       <= out_d;
            err_q       <= err_d;
        end
    end

    assign mem_read    = mem_read_q;
    assign mem_address = mem_addr_q;
    assign pix_valid   = pix_valid_q;
    assign pix_index   = pix_index_q;
    assign outstanding = out_q;
    assign err         = err_q;

endmodule

// File: tb/tb_sprite_fetch.sv
// Bench for sprite_fetch: directed scenarios with literal expectations, then
// randomized traffic against an in-order memory model and a request-queue model.
module tb_sprite_fetch;
    import sprite_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [24:0] req_addr = '0;
    logic        mem_read;
    logic [23:0] mem_address;
    logic        mem_waitrequest = 1'b0;
    logic [15:0] mem_readdata = '0;
    logic        mem_readdatavalid = 1'b0;
    logic        pix_valid;
    logic [7:0]  pix_index;
    logic [2:0]  outstanding;
    logic        err;

    sprite_fetch #(.MAX_OUT(4)) dut (
        .Clk               (Clk),
        .Reset             (Reset),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_addr          (req_addr),
        .mem_read          (mem_read),
        .mem_address       (mem_address),
        .mem_waitrequest   (mem_waitrequest),
        .mem_readdata      (mem_readdata),
        .mem_readdatavalid (mem_readdatavalid),
        .pix_valid         (pix_valid),
        .pix_index         (pix_index),
        .outstanding       (outstanding),
        .err               (err)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: what the block must present, derived from the request history.
    int          m_out;
    bit          m_busy;
    logic [23:0] m_addr;
    logic [24:0] m_tags[$];
    bit          m_pv;
    logic [7:0]  m_pi;
    bit          m_err;
    bit          dut_ready;
    int          cyc = 0;

    typedef struct {
        logic [23:0] wa;
        int          due;
    } mrsp_t;
    mrsp_t mq[$];
    int    last_due = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] word_data(input logic [23:0] wa);
        logic [7:0] hi, lo;
        hi = wa[7:0] ^ wa[23:16] ^ 8'hA5;
        lo = (wa[7:0] * 8'd7) + wa[15:8];
        return {hi, lo};
    endfunction

    function automatic logic [7:0] byte_of(input logic [15:0] w, input logic odd);
        return odd ? w[15:8] : w[7:0];
    endfunction

    task automatic model_reset();
        m_out = 0; m_busy = 0; m_addr = '0; m_tags.delete();
        m_pv = 0; m_pi = '0; m_err = 0;
        mq.delete(); last_due = cyc;
    endtask

    task automatic compare_regs();
        chk("mem_read", 32'(mem_read), 32'(m_busy));
        chk("mem_address", 32'(mem_address), 32'(m_addr));
        chk("pix_valid", 32'(pix_valid), 32'(m_pv));
        chk("pix_index", 32'(pix_index), 32'(m_pi));
        chk("outstanding", 32'(outstanding), 32'(m_out));
        chk("err", 32'(err), 32'(m_err));
    endtask

    // One clock: drive at negedge, check ready, advance model, check registers after posedge.
    task automatic step(input bit rv, input logic [24:0] ra, input bit wr,
                        input bit rdv, input logic [15:0] rd, input bit from_img);
        bit exp_ready, acc, issued, rsp;
        logic [24:0] t;
        @(negedge Clk);
        req_valid = rv; req_addr = ra; mem_waitrequest = wr;
        mem_readdatavalid = rdv; mem_readdata = rd;
        #1;
        exp_ready = (!m_busy || !wr) && (m_out < 4);
        dut_ready = req_ready;
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        acc    = rv && exp_ready;
        issued = m_busy && !wr;
        rsp    = rdv && (m_out > 0);
        m_pv = rsp;
        if (rsp) begin
            t = m_tags.pop_front();
            m_pi = from_img ? byte_of(word_data(t[24:1]), t[0]) : byte_of(rd, t[0]);
        end
        if (rdv && m_out == 0) m_err = 1;
        if (acc) m_tags.push_back(ra);
        m_out = m_out + int'(acc) - int'(rsp);
        if (acc) begin
            m_busy = 1; m_addr = ra[24:1];
        end else if (issued) begin
            m_busy = 0;
        end
        cyc++;
        @(posedge Clk); #1;
        compare_regs();
    endtask

    task automatic idle();
        step(0, '0, 0, 0, '0, 0);
    endtask

    // Random traffic with an in-order memory that answers each issued word read.
    task automatic rand_step(input bit allow_req);
        bit wr, rv, rdv, issued;
        logic [24:0] ra;
        logic [15:0] rd;
        logic [23:0] wa;
        mrsp_t e;
        int due;
        wr  = ($urandom_range(0, 3) == 0);
        rv  = allow_req && ($urandom_range(0, 2) != 0);
        ra  = 25'($urandom);
        rdv = 0;
        rd  = 16'($urandom);
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            e = mq.pop_front();
            rdv = 1;
            rd = word_data(e.wa);
        end
        issued = mem_read && !wr;
        wa = mem_address;
        step(rv, ra, wr, rdv, rd, 1);
        if (issued) begin
            due = cyc + $urandom_range(0, 3);
            if (due < last_due) due = last_due;
            last_due = due;
            e.wa = wa; e.due = due;
            mq.push_back(e);
        end
    endtask

    task automatic do_reset();
        @(negedge Clk); #2;
        Reset = 1; req_valid = 0; mem_waitrequest = 0; mem_readdatavalid = 0;
        #1;
        chk("rst_mem_read", 32'(mem_read), 0);
        chk("rst_mem_address", 32'(mem_address), 0);
        chk("rst_pix_valid", 32'(pix_valid), 0);
        chk("rst_pix_index", 32'(pix_index), 0);
        chk("rst_outstanding", 32'(outstanding), 0);
        chk("rst_err", 32'(err), 0);
        model_reset();
        @(negedge Clk);
        Reset = 0;
        #1;
        chk("ready_after_reset", 32'(req_ready), 1);
    endtask

    initial begin
        do_reset();

        // single odd then even read from the digit image
        step(1, 25'd1166273, 0, 0, '0, 0);
        chk("odd_addr", 32'(mem_address), 32'd583136);
        chk("odd_read", 32'(mem_read), 1);
        idle();
        chk("odd_issued", 32'(mem_read), 0);
        idle();
        step(0, '0, 0, 1, 16'hAB12, 0);
        chk("odd_pv", 32'(pix_valid), 1);
        chk("odd_pix", 32'(pix_index), 32'h AB);
        idle();
        chk("pv_strobe", 32'(pix_valid), 0);
        chk("pix_hold", 32'(pix_index), 32'h AB);
        step(1, 25'd1166272, 0, 0, '0, 0);
        chk("even_addr", 32'(mem_address), 32'd583136);
        idle();
        idle();
        step(0, '0, 0, 1, 16'hAB12, 0);
        chk("even_pix", 32'(pix_index), 32'h12);

        // three stalled cycles, then the command issues
        step(1, 25'(GAMEOVER_BASE + 5), 1, 0, '0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 25'd9, 1, 0, '0, 0);
            chk("stall_ready", 32'(dut_ready), 0);
            chk("stall_read", 32'(mem_read), 1);
            chk("stall_addr", 32'(mem_address), 32'd38882);
        end
        step(0, '0, 0, 0, '0, 0);
        chk("stall_issued", 32'(mem_read), 0);
        step(0, '0, 0, 1, 16'h7788, 0);
        chk("stall_pix", 32'(pix_index), 32'h77);

        // credits and response ordering
        for (int i = 0; i < 4; i++) step(1, 25'(i), 0, 0, '0, 0);
        chk("credit_out4", 32'(outstanding), 4);
        step(1, 25'd100, 0, 0, '0, 0);
        chk("credit_full", 32'(dut_ready), 0);
        step(1, 25'd100, 0, 1, 16'h2211, 0);
        chk("credit_same_cycle", 32'(dut_ready), 0);
        chk("credit_out3", 32'(outstanding), 3);
        chk("order0", 32'(pix_index), 32'h11);
        step(0, '0, 0, 1, 16'h2211, 0);
        chk("credit_freed", 32'(dut_ready), 1);
        chk("order1", 32'(pix_index), 32'h22);
        step(0, '0, 0, 1, 16'h4433, 0);
        chk("order2", 32'(pix_index), 32'h33);
        step(0, '0, 0, 1, 16'h4433, 0);
        chk("order3", 32'(pix_index), 32'h44);
        chk("order_drained", 32'(outstanding), 0);

        // stray response, then reset with reads in flight
        step(0, '0, 0, 1, 16'hFFFF, 0);
        chk("stray_err", 32'(err), 1);
        chk("stray_no_pv", 32'(pix_valid), 0);
        step(1, 25'(GRADE_BASE), 0, 0, '0, 0);
        step(1, 25'(GRADE_BASE + 1), 0, 0, '0, 0);
        idle();
        chk("inflight2", 32'(outstanding), 2);
        do_reset();
        step(0, '0, 0, 1, 16'h1234, 0);
        chk("late_err", 32'(err), 1);
        chk("late_no_pv", 32'(pix_valid), 0);
        do_reset();

        // randomized traffic
        for (int i = 0; i < 3000; i++) rand_step(1);
        for (int i = 0; i < 300 && (m_out > 0 || mq.size() > 0); i++) rand_step(0);
        chk("drain_done", 32'(outstanding), 0);
        chk("drain_err_clear", 32'(err), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
